// File: rtl/ex_stage.sv
// RV64I execute stage: forwarding muxes, ALU control and ALU, branch resolution,
// and the EX/MEM pipeline register with stall and flush.
module ex_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic [XLEN-1:0]   immediate,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              branch,
  input  logic              memRead,
  input  logic              memToReg,
  input  logic              memWrite,
  input  logic              aluSRC,
  input  logic              regWrite,
  input  logic [1:0]        aluOp,
  input  logic              mem_wb_regWrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic [XLEN-1:0]   mem_wb_data,
  input  logic              stall,
  input  logic              flush,
  output logic [XLEN-1:0]   alu_result_reg,
  output logic [XLEN-1:0]   store_data_reg,
  output logic [XLEN-1:0]   branch_target_reg,
  output logic              branch_taken_reg,
  output logic [REG_AW-1:0] rd_reg,
  output logic              memRead_reg,
  output logic              memToReg_reg,
  output logic              memWrite_reg,
  output logic              regWrite_reg
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  logic [REG_AW-1:0] src_idx [2];
  logic [XLEN-1:0]   src_val [2];
  logic [XLEN-1:0]   fwd_val [2];

  assign src_idx[0] = rs1;
  assign src_idx[1] = rs2;
  assign src_val[0] = rd1;
  assign src_val[1] = rd2;

  // EX/MEM beats MEM/WB; x0 is never a forwarding target.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic ex_hit;
      logic wb_hit;
      assign ex_hit = regWrite_reg && (rd_reg != '0) && (rd_reg == src_idx[gi]);
      assign wb_hit = mem_wb_regWrite && (mem_wb_rd != '0) && (mem_wb_rd == src_idx[gi]);
      assign fwd_val[gi] = ex_hit ? alu_result_reg : (wb_hit ? mem_wb_data : src_val[gi]);
    end
  endgenerate

  logic [XLEN-1:0] fwd_a, fwd_b, alu_b, diff, alu_y;
  logic [5:0]      shamt;
  logic            zero;
  alu_op_t         alu_op;

  assign fwd_a = fwd_val[0];
  assign fwd_b = fwd_val[1];
  assign alu_b = aluSRC ? immediate : fwd_b;
  assign shamt = alu_b[5:0];
  assign diff  = fwd_a - alu_b;
  assign zero  = (diff == '0);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_op = ALU_ADD;
    case (aluOp)
      2'b00: alu_op = ALU_ADD;
      2'b01: alu_op = ALU_SUB;
      default: begin
        case (funct3)
          // I-type has no subi, so funct7 only selects sub for R-type.
          3'b000: alu_op = (aluOp == 2'b10 && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = fwd_a + alu_b;
      ALU_SUB:  alu_y = diff;
      ALU_SLL:  alu_y = fwd_a << shamt;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (fwd_a < alu_b)};
      ALU_XOR:  alu_y = fwd_a ^ alu_b;
      ALU_SRL:  alu_y = fwd_a >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(fwd_a) >>> shamt);
      ALU_OR:   alu_y = fwd_a | alu_b;
      ALU_AND:  alu_y = fwd_a & alu_b;
      default:  alu_y = '0;
    endcase
  end

  logic branch_taken_next;
  assign branch_taken_next = branch &
      ((funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? ~zero : 1'b0);

  // Flush still loads the data fields; only the side-effecting controls are squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_reg    <= '0;
      store_data_reg    <= '0;
      branch_target_reg <= '0;
      rd_reg            <= '0;
      branch_taken_reg  <= 1'b0;
      memRead_reg       <= 1'b0;
      memToReg_reg      <= 1'b0;
      memWrite_reg      <= 1'b0;
      regWrite_reg      <= 1'b0;
    end else if (flush || !stall) begin
      alu_result_reg    <= alu_y;
      store_data_reg    <= fwd_b;
      branch_target_reg <= pc + immediate;
      rd_reg            <= rd;
      branch_taken_reg  <= branch_taken_next & ~flush;
      memRead_reg       <= memRead & ~flush;
      memToReg_reg      <= memToReg & ~flush;
      memWrite_reg      <= memWrite & ~flush;
      regWrite_reg      <= regWrite & ~flush;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, forwarding priority,
// branch resolution, stall/flush and asynchronous reset.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] pc, rd1, rd2, immediate, mem_wb_data;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd, mem_wb_rd;
  logic        branch, memRead, memToReg, memWrite, aluSRC, regWrite;
  logic [1:0]  aluOp;
  logic        mem_wb_regWrite, stall, flush;
  logic [63:0] alu_result_reg, store_data_reg, branch_target_reg;
  logic        branch_taken_reg;
  logic [4:0]  rd_reg;
  logic        memRead_reg, memToReg_reg, memWrite_reg, regWrite_reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .rd1(rd1), .rd2(rd2), .immediate(immediate),
    .funct7(funct7), .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
    .branch(branch), .memRead(memRead), .memToReg(memToReg), .memWrite(memWrite),
    .aluSRC(aluSRC), .regWrite(regWrite), .aluOp(aluOp),
    .mem_wb_regWrite(mem_wb_regWrite), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .stall(stall), .flush(flush),
    .alu_result_reg(alu_result_reg), .store_data_reg(store_data_reg),
    .branch_target_reg(branch_target_reg), .branch_taken_reg(branch_taken_reg),
    .rd_reg(rd_reg), .memRead_reg(memRead_reg), .memToReg_reg(memToReg_reg),
    .memWrite_reg(memWrite_reg), .regWrite_reg(regWrite_reg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    pc = '0; rd1 = '0; rd2 = '0; immediate = '0; funct7 = '0; funct3 = '0;
    rs1 = '0; rs2 = '0; rd = '0; branch = 0; memRead = 0; memToReg = 0;
    memWrite = 0; aluSRC = 0; regWrite = 0; aluOp = 2'b00;
    mem_wb_regWrite = 0; mem_wb_rd = '0; mem_wb_data = '0; stall = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t alu=0x%0h rd=%0d rw=%0b mw=%0b bt=%0b tgt=0x%0h", $time,
             alu_result_reg, rd_reg, regWrite_reg, memWrite_reg, branch_taken_reg,
             branch_target_reg);
  endtask

  // R-type with no forwarding (rs1=rs2=x0), writes x1
  task automatic r_op(input logic [2:0] f3, input logic [6:0] f7,
                      input logic [63:0] a, input logic [63:0] b);
    nop();
    aluOp = 2'b10; funct3 = f3; funct7 = f7; rd1 = a; rd2 = b; rd = 5'd1; regWrite = 1;
  endtask

  initial begin
    nop();
    rst_n = 1'b0;
    #3;
    check("reset_alu", alu_result_reg, 64'd0);
    check("reset_rw", regWrite_reg, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add then asynchronous reset between edges
    r_op(3'b000, 7'h00, 64'd2, 64'd3); rd = 5'd4;
    tick();
    check("add_pre_reset", alu_result_reg, 64'd5);
    check("add_rw", regWrite_reg, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_alu", alu_result_reg, 64'd0);
    check("async_rst_rw", regWrite_reg, 64'd0);
    check("async_rst_rd", rd_reg, 64'd0);
    rst_n = 1'b1;

    r_op(3'b000, 7'h20, 64'd10, 64'd3); tick();
    check("sub", alu_result_reg, 64'd7);
    r_op(3'b101, 7'h20, 64'h8000000000000000, 64'd4); tick();
    check("sra", alu_result_reg, 64'hF800000000000000);
    r_op(3'b101, 7'h00, 64'h8000000000000000, 64'd4); tick();
    check("srl", alu_result_reg, 64'h0800000000000000);
    r_op(3'b010, 7'h00, 64'hFFFFFFFFFFFFFFFF, 64'd1); tick();
    check("slt", alu_result_reg, 64'd1);
    r_op(3'b011, 7'h00, 64'hFFFFFFFFFFFFFFFF, 64'd1); tick();
    check("sltu", alu_result_reg, 64'd0);
    r_op(3'b100, 7'h00, 64'hF0F0, 64'hFF00); tick();
    check("xor", alu_result_reg, 64'h0FF0);
    r_op(3'b110, 7'h00, 64'hF0F0, 64'hFF00); tick();
    check("or", alu_result_reg, 64'hFFF0);
    r_op(3'b111, 7'h00, 64'hF0F0, 64'hFF00); tick();
    check("and", alu_result_reg, 64'hF000);
    r_op(3'b001, 7'h00, 64'd1, 64'd0); aluOp = 2'b11; aluSRC = 1; immediate = 64'd63; tick();
    check("slli63", alu_result_reg, 64'h8000000000000000);

    // EX/MEM forwarding; addi with funct7[5]=1 must still add
    nop(); aluOp = 2'b11; aluSRC = 1; immediate = 64'd5; funct7 = 7'h20; rd = 5'd5; regWrite = 1;
    tick();
    check("addi_f7", alu_result_reg, 64'd5);
    nop(); aluOp = 2'b10; rd = 5'd6; rs1 = 5'd5; rs2 = 5'd5; regWrite = 1;
    tick();
    check("fwd_exmem", alu_result_reg, 64'd10);

    nop(); aluOp = 2'b11; aluSRC = 1; immediate = 64'd5; rd = 5'd0; regWrite = 1;
    tick();
    check("addi_x0", alu_result_reg, 64'd5);
    nop(); aluOp = 2'b10; rd = 5'd6; rs1 = 5'd0; rs2 = 5'd0; regWrite = 1;
    tick();
    check("fwd_x0_none", alu_result_reg, 64'd0);

    // MEM/WB forwarding on a load address
    nop(); aluSRC = 1; memRead = 1; memToReg = 1; regWrite = 1; rd = 5'd8;
    rs1 = 5'd7; rd1 = 64'd1; immediate = 64'd4;
    mem_wb_regWrite = 1; mem_wb_rd = 5'd7; mem_wb_data = 64'd100;
    tick();
    check("fwd_memwb", alu_result_reg, 64'd104);
    check("load_mr", memRead_reg, 64'd1);
    check("load_m2r", memToReg_reg, 64'd1);

    nop(); aluOp = 2'b11; aluSRC = 1; immediate = 64'd50; rd = 5'd7; regWrite = 1;
    mem_wb_regWrite = 1; mem_wb_rd = 5'd7; mem_wb_data = 64'd100;
    tick();
    check("addi_x7", alu_result_reg, 64'd50);
    nop(); aluSRC = 1; memRead = 1; memToReg = 1; regWrite = 1; rd = 5'd8;
    rs1 = 5'd7; rd1 = 64'd1; immediate = 64'd4;
    mem_wb_regWrite = 1; mem_wb_rd = 5'd7; mem_wb_data = 64'd100;
    tick();
    check("fwd_priority", alu_result_reg, 64'd54);

    nop(); aluSRC = 1; rs1 = 5'd7; rd1 = 64'd1; immediate = 64'd4;
    mem_wb_regWrite = 0; mem_wb_rd = 5'd7; mem_wb_data = 64'd100;
    tick();
    check("memwb_disabled", alu_result_reg, 64'd5);

    // branches
    nop(); branch = 1; aluOp = 2'b01; funct3 = 3'b000; pc = 64'h100; immediate = 64'h20;
    rd1 = 64'd9; rd2 = 64'd9;
    tick();
    check("beq_taken", branch_taken_reg, 64'd1);
    check("beq_target", branch_target_reg, 64'h120);
    funct3 = 3'b001;
    tick();
    check("bne_not_taken", branch_taken_reg, 64'd0);
    rd2 = 64'd8;
    tick();
    check("bne_taken", branch_taken_reg, 64'd1);

    // store
    nop(); aluSRC = 1; memWrite = 1; rd1 = 64'h1000; immediate = 64'd8; rd2 = 64'hDEAD;
    tick();
    check("store_addr", alu_result_reg, 64'h1008);
    check("store_data", store_data_reg, 64'hDEAD);
    check("store_mw", memWrite_reg, 64'd1);

    // stall holds, then forwarding from held EX/MEM values
    nop(); aluOp = 2'b10; rd1 = 64'd1; rd2 = 64'd2; rd = 5'd9; regWrite = 1; stall = 1;
    tick();
    check("stall_alu", alu_result_reg, 64'h1008);
    check("stall_mw", memWrite_reg, 64'd1);
    check("stall_rw", regWrite_reg, 64'd0);
    stall = 0;
    tick();
    check("unstall_alu", alu_result_reg, 64'd3);
    check("unstall_rd", rd_reg, 64'd9);
    nop(); aluOp = 2'b10; rs1 = 5'd9; rd1 = 64'd0; rd2 = 64'd10; rd = 5'd10; regWrite = 1; stall = 1;
    tick();
    check("stall2_alu", alu_result_reg, 64'd3);
    stall = 0;
    tick();
    check("fwd_held", alu_result_reg, 64'd13);

    // flush
    nop(); aluSRC = 1; regWrite = 1; memWrite = 1; rd1 = 64'h40; immediate = 64'd4;
    rd = 5'd11; flush = 1;
    tick();
    check("flush_rw", regWrite_reg, 64'd0);
    check("flush_mw", memWrite_reg, 64'd0);
    check("flush_data", alu_result_reg, 64'h44);
    check("flush_rd", rd_reg, 64'd11);

    nop(); branch = 1; aluOp = 2'b01; funct3 = 3'b000; pc = 64'h200; immediate = 64'h10;
    rd1 = 64'd9; rd2 = 64'd9; memRead = 1; regWrite = 1; flush = 1; stall = 1;
    tick();
    check("flushstall_bt", branch_taken_reg, 64'd0);
    check("flushstall_mr", memRead_reg, 64'd0);
    check("flushstall_rw", regWrite_reg, 64'd0);
    check("flushstall_tgt", branch_target_reg, 64'h210);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV64I pipeline. Consumes the ID/EX pipeline register outputs and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Performs the ALU operation and branch resolution, then registers the results into the EX/MEM pipeline register consumed by the memory stage.
- Contains the ALU control decode, forwarding muxes and the EX/MEM register with stall/flush.

Parameters:
- XLEN, 64, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc  in  XLEN  PC of instruction in EX
- rd1  in  XLEN  register rs1 value from ID/EX
- rd2  in  XLEN  register rs2 value from ID/EX
- immediate  in  XLEN  sign-extended byte-offset immediate
- funct7  in  7  instruction funct7
- funct3  in  3  instruction funct3
- rs1, rs2, rd  in  REG_AW each  register indices
- branch, memRead, memToReg, memWrite, aluSRC, regWrite  in  1 each  control from ID/EX
- aluOp  in  2  ALU class
- mem_wb_regWrite  in  1  MEM/WB write enable
- mem_wb_rd  in  REG_AW  MEM/WB destination
- mem_wb_data  in  XLEN  MEM/WB writeback value
- stall  in  1  hold EX/MEM register
- flush  in  1  squash instruction entering EX/MEM
- alu_result_reg  out  XLEN  registered ALU result / memory address
- store_data_reg  out  XLEN  registered forwarded rs2 value
- branch_target_reg  out  XLEN  registered pc+immediate
- branch_taken_reg  out  1  registered branch decision (PCSrc)
- rd_reg  out  REG_AW  registered destination
- memRead_reg, memToReg_reg, memWrite_reg, regWrite_reg  out  1 each  registered controls

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0. Release is synchronous to the next clk edge.
- Latency: 1 cycle. Outputs reflect the inputs sampled at the previous rising edge.
- Forwarding, operand A, priority order:
  - EX/MEM: regWrite_reg=1, rd_reg!=0, rd_reg==rs1 -> alu_result_reg.
  - Else MEM/WB: mem_wb_regWrite=1, mem_wb_rd!=0, mem_wb_rd==rs1 -> mem_wb_data.
  - Else rd1.
- Operand B forwarding uses the same rules with rs2/rd2 and yields fwd_b.
- No forwarding ever targets x0. Load-use hazards are stalled upstream; this block does not detect them.
- ALU B input = aluSRC ? immediate : fwd_b. store_data_reg captures fwd_b.
- ALU control:
  - aluOp=00: add (load/store address).
  - aluOp=01: sub (branch compare).
  - aluOp=10 (R-type), by funct3:
    - 000: add, or sub if funct7[5]=1
    - 001: sll
    - 010: slt (signed)
    - 011: sltu
    - 100: xor
    - 101: srl, or sra if funct7[5]=1
    - 110: or
    - 111: and
  - aluOp=11 (I-type): same decode, except funct3=000 is always add. Shift type is still chosen by funct7[5].
- Shift amount is B[5:0]. All arithmetic is modulo 2^XLEN with overflow ignored. slt/sltu produce 0 or 1, zero-extended.
- Branch: zero = (A−B)==0.
  - branch_taken = branch & (funct3==000 ? zero : funct3==001 ? !zero : 0).
  - branch_target = pc + immediate, mod 2^XLEN.
- EX/MEM register update at the rising edge:
  - flush=1: memRead, memToReg, memWrite, regWrite and branch_taken registers become 0. Data registers load normally. flush has priority over stall.
  - else stall=1: all output registers hold their values.
  - else: all output registers load new values.
- During stall, forwarding from EX/MEM keeps using the held register values.

Test Plan:
- Reset mid-operation: drive an add with regWrite=1, then pulse rst_n=0 between edges -> all outputs 0 immediately, without waiting for a clock edge.
- R-type ALU, aluOp=10, funct3=000, funct7=0x20, rd1=10, rd2=3 -> alu_result_reg=7 one cycle later. Same with funct3=101, funct7=0x20, rd1=0x8000000000000000, rd2=4 -> 0xF800000000000000.
- EX/MEM forwarding: cycle 1 addi x5=x0+5 (aluOp=11, aluSRC=1, imm=5). Cycle 2 add rd=x6, rs1=x5, rs2=x5, rd1=0, rd2=0 -> alu_result_reg=10.
  - Same sequence with rd=x0 in cycle 1 -> cycle 2 result 0.
- MEM/WB forwarding and priority:
  - mem_wb_regWrite=1, mem_wb_rd=7, mem_wb_data=100, rs1=7, rd1=1, imm=4 on a load -> alu_result_reg=104.
  - With EX/MEM also writing x7=50 -> EX/MEM wins, result 54.
- Branch: beq pc=0x100, imm=0x20, rd1=rd2=9 -> branch_taken_reg=1, branch_target_reg=0x120. bne with the same operands -> branch_taken_reg=0.
- Stall/flush:
  - stall=1 across a new add -> outputs unchanged for that cycle.
  - flush=1 with regWrite=1, memWrite=1 -> regWrite_reg=0, memWrite_reg=0.
  - flush=1 and stall=1 together -> controls cleared.
